// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL in-flight monitor. Tracks outstanding A-channel
// requests by source ID, checks every D-channel response against its table
// entry, and reports protocol violations as a registered one-cycle error
// pulse, a lowest-code error number and a sticky per-code error vector.
module tl_inflight_monitor #(
    parameter int SOURCE_BITS    = 12,
    parameter int ADDR_BITS      = 15,
    parameter int MASK_BITS      = 4,
    parameter int SIZE_BITS      = 2,
    parameter int MAX_INFLIGHT   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic [MASK_BITS-1:0]   a_mask,
    input  logic                   a_corrupt,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [15:0]            err_sticky,
    output logic [5:0]             inflight_count
);

    localparam int AGE_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int IDX_W   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int LG_MASK = $clog2(MASK_BITS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

    // True when addr is not a multiple of 2^sz.
    function automatic logic misaligned(input logic [ADDR_BITS-1:0] addr,
                                        input logic [SIZE_BITS-1:0] sz);
        logic [ADDR_BITS-1:0] low_mask;
        low_mask = (ADDR_BITS'(1) << sz) - ADDR_BITS'(1);
        return |(addr & low_mask);
    endfunction

    // Lowest set code number in a failure vector; 0 when nothing failed.
    function automatic logic [3:0] lowest_code(input logic [15:0] f);
        logic [3:0] code;
        code = 4'd0;
        for (int k = 15; k >= 1; k--) begin
            code = f[k] ? 4'(k) : code;
        end
        return code;
    endfunction

    // Tracking table
    logic [MAX_INFLIGHT-1:0] valid_q;
    logic [MAX_INFLIGHT-1:0] tflag_q;
    logic [MAX_INFLIGHT-1:0] expd_q;
    logic [SOURCE_BITS-1:0]  src_q  [MAX_INFLIGHT];
    logic [SIZE_BITS-1:0]    size_q [MAX_INFLIGHT];
    logic [AGE_W-1:0]        age_q  [MAX_INFLIGHT];

    // Previous-cycle A channel snapshot for the stall-stability check
    logic                    stall_q;
    logic [2:0]              prev_opcode_q;
    logic [2:0]              prev_param_q;
    logic [SIZE_BITS-1:0]    prev_size_q;
    logic [SOURCE_BITS-1:0]  prev_source_q;
    logic [ADDR_BITS-1:0]    prev_address_q;
    logic [MASK_BITS-1:0]    prev_mask_q;
    logic                    prev_corrupt_q;

    // Output registers
    logic                    err_valid_q;
    logic [3:0]              err_code_q;
    logic [15:0]             err_sticky_q;
    logic [5:0]              count_q;

    // Combinational decode
    logic                    a_fire_s;
    logic                    d_fire_s;
    logic [MAX_INFLIGHT-1:0] d_match_s;
    logic                    d_hit_s;
    logic [IDX_W-1:0]        d_idx_s;
    logic                    retire_s;
    logic [MAX_INFLIGHT-1:0] retire_vec_s;
    logic [MAX_INFLIGHT-1:0] live_s;
    logic [MAX_INFLIGHT-1:0] a_match_s;
    logic                    dup_s;
    logic                    free_found_s;
    logic [IDX_W-1:0]        free_idx_s;
    logic                    opc_ok_s;
    logic                    alloc_s;
    logic [MAX_INFLIGHT-1:0] to_vec_s;
    logic                    a_changed_s;
    logic [15:0]             fail_s;
    logic                    err_valid_d;
    logic [3:0]              err_code_d;

    // Per-entry source comparison against the D response and timeout detect.
    always_comb begin
        a_fire_s  = a_valid & a_ready;
        d_fire_s  = d_valid & d_ready;
        d_match_s = '0;
        to_vec_s  = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            d_match_s[i] = valid_q[i] & (src_q[i] == d_source);
            to_vec_s[i]  = TMO_EN & valid_q[i] & ~tflag_q[i] & (age_q[i] == AGE_MAX);
        end
    end

    // Retire first, then look up the A request against the surviving entries.
    always_comb begin
        d_hit_s      = 1'b0;
        d_idx_s      = '0;
        retire_vec_s = '0;
        a_match_s    = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            d_hit_s = d_hit_s | d_match_s[i];
            d_idx_s = d_match_s[i] ? IDX_W'(i) : d_idx_s;
        end
        retire_s = d_fire_s & d_hit_s;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            retire_vec_s[i] = retire_s & (d_idx_s == IDX_W'(i));
        end
        live_s = valid_q & ~retire_vec_s;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            a_match_s[i] = live_s[i] & (src_q[i] == a_source);
            free_found_s = free_found_s | ~live_s[i];
            free_idx_s   = live_s[i] ? free_idx_s : IDX_W'(i);
        end
        dup_s    = |a_match_s;
        opc_ok_s = (a_opcode == 3'd0) | (a_opcode == 3'd1) | (a_opcode == 3'd4);
        alloc_s  = a_fire_s & opc_ok_s & ~dup_s & free_found_s;
    end

    // Collect every failing check this cycle and pick the lowest code.
    always_comb begin
        a_changed_s = (a_opcode != prev_opcode_q) | (a_param != prev_param_q) |
                      (a_size != prev_size_q) | (a_source != prev_source_q) |
                      (a_address != prev_address_q) | (a_mask != prev_mask_q) |
                      (a_corrupt != prev_corrupt_q);
        fail_s      = 16'd0;
        fail_s[1]   = a_fire_s & ~opc_ok_s;
        fail_s[2]   = a_fire_s & (misaligned(a_address, a_size) |
                                  (int'(a_size) > LG_MASK) | (a_param != 3'd0));
        fail_s[3]   = a_fire_s & dup_s;
        fail_s[4]   = a_fire_s & opc_ok_s & ~dup_s & ~free_found_s;
        fail_s[5]   = d_fire_s & ~d_hit_s;
        fail_s[6]   = retire_s & (d_opcode != (expd_q[d_idx_s] ? 3'd1 : 3'd0));
        fail_s[7]   = retire_s & (d_size != size_q[d_idx_s]);
        fail_s[8]   = |to_vec_s;
        fail_s[9]   = stall_q & a_valid & a_changed_s;
        fail_s[10]  = a_fire_s & (a_opcode == 3'd4) & a_corrupt;
        err_valid_d = |fail_s;
        err_code_d  = lowest_code(fail_s);
    end

    // Tracking table: allocate, retire, age and mark timed-out entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tflag_q <= '0;
            expd_q  <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                src_q[i]  <= '0;
                size_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (alloc_s && (free_idx_s == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    src_q[i]   <= a_source;
                    size_q[i]  <= a_size;
                    expd_q[i]  <= (a_opcode == 3'd4);
                    age_q[i]   <= '0;
                    tflag_q[i] <= 1'b0;
                end else if (retire_vec_s[i]) begin
                    valid_q[i] <= 1'b0;
                    age_q[i]   <= '0;
                    tflag_q[i] <= 1'b0;
                end else if (valid_q[i]) begin
                    if (age_q[i] != AGE_MAX) begin
                        age_q[i] <= age_q[i] + AGE_W'(1);
                    end
                    tflag_q[i] <= tflag_q[i] | to_vec_s[i];
                end
            end
        end
    end

    // Remember last cycle's A channel so a stalled request can be checked for stability.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q        <= 1'b0;
            prev_opcode_q  <= '0;
            prev_param_q   <= '0;
            prev_size_q    <= '0;
            prev_source_q  <= '0;
            prev_address_q <= '0;
            prev_mask_q    <= '0;
            prev_corrupt_q <= 1'b0;
        end else begin
            stall_q        <= a_valid & ~a_ready;
            prev_opcode_q  <= a_opcode;
            prev_param_q   <= a_param;
            prev_size_q    <= a_size;
            prev_source_q  <= a_source;
            prev_address_q <= a_address;
            prev_mask_q    <= a_mask;
            prev_corrupt_q <= a_corrupt;
        end
    end

    // Registered error reporting and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_valid_q  <= 1'b0;
            err_code_q   <= 4'd0;
            err_sticky_q <= 16'd0;
            count_q      <= 6'd0;
        end else begin
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_q | fail_s;
            count_q      <= count_q + 6'(alloc_s) - 6'(retire_s);
        end
    end

    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign err_sticky     = err_sticky_q;
    assign inflight_count = count_q;

endmodule
